// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings and lane-arbiter FSM types
package alu_pkg;

    localparam logic [2:0] CORE_STATE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_STATE_EXECUTE = 3'b101;

    typedef enum logic [1:0] {
        ARITH_ADD = 2'b00,
        ARITH_SUB = 2'b01,
        ARITH_MUL = 2'b10,
        ARITH_DIV = 2'b11
    } arith_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_ISSUE   = 2'b01,
        ARB_CAPTURE = 2'b10
    } arb_state_e;

    // Compare result layout: {zeros, N, Z, P}
    localparam int NZP_P_BIT = 0;
    localparam int NZP_Z_BIT = 1;
    localparam int NZP_N_BIT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick over an eligible mask
module rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int IDX_BITS  = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] eligible_i,
    input  logic [IDX_BITS-1:0]  rr_ptr_i,
    output logic [NUM_LANES-1:0] grant_o,
    output logic [IDX_BITS-1:0]  grant_idx_o,
    output logic                 valid_o
);

    // Walk lanes starting at rr_ptr, wrapping; the first eligible lane wins
    always_comb begin
        logic                found;
        logic [IDX_BITS-1:0] cand;
        found       = 1'b0;
        cand        = '0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = IDX_BITS'((int'(rr_ptr_i) + k) % NUM_LANES);
            if (!found && eligible_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/alu_lane_arbiter.sv
// rtl/alu_lane_arbiter.sv - round-robin sharing of one ALU across thread lanes
module alu_lane_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           req_valid,
    input  logic [2*NUM_LANES-1:0]         req_op,
    input  logic [NUM_LANES-1:0]           req_cmp,
    input  logic [DATA_BITS*NUM_LANES-1:0] req_rs,
    input  logic [DATA_BITS*NUM_LANES-1:0] req_rt,
    output logic [NUM_LANES-1:0]           req_grant,
    output logic [NUM_LANES-1:0]           resp_valid,
    output logic [DATA_BITS*NUM_LANES-1:0] resp_data,
    output logic [NUM_LANES-1:0]           resp_err,
    input  logic [NUM_LANES-1:0]           resp_ack,
    output logic                           alu_enable,
    output logic [2:0]                     alu_core_state,
    output logic [1:0]                     alu_arith_mux,
    output logic                           alu_output_mux,
    output logic [DATA_BITS-1:0]           alu_rs,
    output logic [DATA_BITS-1:0]           alu_rt,
    input  logic [DATA_BITS-1:0]           alu_result,
    output logic                           busy
);

    localparam int IDX_BITS = $clog2(NUM_LANES);

    arb_state_e                     state_q, state_d;
    logic [IDX_BITS-1:0]            win_idx_q;
    logic [IDX_BITS-1:0]            rr_ptr_q;
    arith_op_e                      op_q;
    logic                           cmp_q;
    logic [DATA_BITS-1:0]           rs_q, rt_q;
    logic [NUM_LANES-1:0]           resp_valid_q, resp_err_q;
    logic [DATA_BITS*NUM_LANES-1:0] resp_data_q;

    logic [NUM_LANES-1:0]           win_onehot_q;
    logic [NUM_LANES-1:0]           capture_mask;
    logic [NUM_LANES-1:0]           eligible;
    logic [NUM_LANES-1:0]           pick_onehot;
    logic [IDX_BITS-1:0]            pick_idx;
    logic                           pick_valid;
    logic                           latch_en;
    logic                           div_zero;

    assign win_onehot_q = NUM_LANES'(1) << win_idx_q;

    // The lane being captured already has its result committed this edge,
    // so it must not win the same-cycle rearbitration.
    assign capture_mask = (state_q == ARB_CAPTURE) ? win_onehot_q : '0;
    assign eligible     = req_valid & ~resp_valid_q & ~capture_mask;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .IDX_BITS  (IDX_BITS)
    ) u_rr_arbiter (
        .eligible_i  (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_onehot),
        .grant_idx_o (pick_idx),
        .valid_o     (pick_valid)
    );

    // A zero-divisor arithmetic DIV bypasses the ALU value with all-ones
    assign div_zero = (op_q == ARITH_DIV) && !cmp_q && (rt_q == '0);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state, grant pulse and ALU control
    always_comb begin
        state_d        = state_q;
        latch_en       = 1'b0;
        req_grant      = '0;
        alu_enable     = 1'b0;
        alu_core_state = CORE_STATE_IDLE;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_ISSUE;
                    latch_en = 1'b1;
                end
            end
            ARB_ISSUE: begin
                req_grant      = win_onehot_q;
                alu_enable     = 1'b1;
                alu_core_state = CORE_STATE_EXECUTE;
                state_d        = ARB_CAPTURE;
            end
            ARB_CAPTURE: begin
                if (pick_valid) begin
                    state_d  = ARB_ISSUE;
                    latch_en = 1'b1;
                end else begin
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Latch the winner's operands; they also feed the ALU and so hold between ops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_idx_q <= '0;
            op_q      <= ARITH_ADD;
            cmp_q     <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
        end else if (latch_en) begin
            win_idx_q <= pick_idx;
            op_q      <= arith_op_e'(req_op[2*int'(pick_idx) +: 2]);
            cmp_q     <= req_cmp[pick_idx];
            rs_q      <= req_rs[DATA_BITS*int'(pick_idx) +: DATA_BITS];
            rt_q      <= req_rt[DATA_BITS*int'(pick_idx) +: DATA_BITS];
        end
    end

    // Round-robin pointer advances past the lane granted this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else if (state_q == ARB_ISSUE) begin
            rr_ptr_q <= (win_idx_q == IDX_BITS'(NUM_LANES-1)) ? '0 : win_idx_q + 1'b1;
        end
    end

    // Per-lane result registers: acks clear, capture of the winner sets
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= '0;
            resp_err_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (resp_ack[i] && resp_valid_q[i]) begin
                    resp_valid_q[i] <= 1'b0;
                    resp_err_q[i]   <= 1'b0;
                end
            end
            if (state_q == ARB_CAPTURE) begin
                resp_valid_q[win_idx_q] <= 1'b1;
                resp_err_q[win_idx_q]   <= div_zero;
                resp_data_q[DATA_BITS*int'(win_idx_q) +: DATA_BITS] <=
                    div_zero ? {DATA_BITS{1'b1}} : alu_result;
            end
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_data      = resp_data_q;
    assign alu_arith_mux  = op_q;
    assign alu_output_mux = cmp_q;
    assign alu_rs         = rs_q;
    assign alu_rt         = rt_q;
    assign busy           = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_alu_lane_arbiter.sv
// tb/tb_alu_lane_arbiter.sv - directed self-checking bench for alu_lane_arbiter
module tb_alu_lane_arbiter;
    import alu_pkg::*;

    localparam int NL = 4;
    localparam int DB = 8;

    logic            clk;
    logic            rst_n;
    logic [NL-1:0]   req_valid;
    logic [2*NL-1:0] req_op;
    logic [NL-1:0]   req_cmp;
    logic [DB*NL-1:0] req_rs;
    logic [DB*NL-1:0] req_rt;
    logic [NL-1:0]   req_grant;
    logic [NL-1:0]   resp_valid;
    logic [DB*NL-1:0] resp_data;
    logic [NL-1:0]   resp_err;
    logic [NL-1:0]   resp_ack;
    logic            alu_enable;
    logic [2:0]      alu_core_state;
    logic [1:0]      alu_arith_mux;
    logic            alu_output_mux;
    logic [DB-1:0]   alu_rs;
    logic [DB-1:0]   alu_rt;
    logic [DB-1:0]   alu_result;
    logic            busy;

    int n_checks;
    int n_fail;
    logic [NL-1:0] gseen;

    alu_lane_arbiter #(.NUM_LANES(NL), .DATA_BITS(DB)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_cmp        (req_cmp),
        .req_rs         (req_rs),
        .req_rt         (req_rt),
        .req_grant      (req_grant),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .resp_ack       (resp_ack),
        .alu_enable     (alu_enable),
        .alu_core_state (alu_core_state),
        .alu_arith_mux  (alu_arith_mux),
        .alu_output_mux (alu_output_mux),
        .alu_rs         (alu_rs),
        .alu_rt         (alu_rt),
        .alu_result     (alu_result),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU: registered result when enabled in EXECUTE
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
        end else if (alu_enable && alu_core_state == 3'b101) begin
            if (alu_output_mux) begin
                alu_result            <= '0;
                alu_result[NZP_N_BIT] <= alu_rs < alu_rt;
                alu_result[NZP_Z_BIT] <= alu_rs == alu_rt;
                alu_result[NZP_P_BIT] <= alu_rs > alu_rt;
            end else begin
                case (alu_arith_mux)
                    2'b00:   alu_result <= alu_rs + alu_rt;
                    2'b01:   alu_result <= alu_rs - alu_rt;
                    2'b10:   alu_result <= alu_rs * alu_rt;
                    default: alu_result <= (alu_rt == 0) ? 8'h00 : alu_rs / alu_rt;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DB-1:0] lane_data(input int lane);
        return resp_data[DB*lane +: DB];
    endfunction

    // Advance one edge; a lane drops its request once it sees its grant
    task automatic tick();
        @(posedge clk);
        #1;
        gseen     = gseen | req_grant;
        req_valid = req_valid & ~req_grant;
    endtask

    task automatic set_req(input int lane, input logic [1:0] op, input logic cmp,
                           input logic [7:0] rs, input logic [7:0] rt);
        req_valid[lane]       = 1'b1;
        req_op[2*lane +: 2]   = op;
        req_cmp[lane]         = cmp;
        req_rs[DB*lane +: DB] = rs;
        req_rt[DB*lane +: DB] = rt;
    endtask

    task automatic wait_resp(input logic [NL-1:0] mask, input string tag);
        int n;
        n = 0;
        while (((resp_valid & mask) != mask) && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(resp_valid & mask), 32'(mask));
    endtask

    task automatic ack(input logic [NL-1:0] mask);
        resp_ack = mask;
        tick();
        resp_ack = '0;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_op    = '0;
        req_cmp   = '0;
        req_rs    = '0;
        req_rt    = '0;
        resp_ack  = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        gseen    = '0;
        do_reset();

        // Reset state
        check("rst_grant", 32'(req_grant), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_core_state", 32'(alu_core_state), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);

        // Single ADD on lane0: latency and ISSUE-only EXECUTE
        tick();
        set_req(0, 2'b00, 1'b0, 8'd10, 8'd20);
        tick();
        check("t1_grant", 32'(req_grant), 32'h1);
        check("t1_core_state_issue", 32'(alu_core_state), 32'h5);
        check("t1_enable_issue", 32'(alu_enable), 32'h1);
        check("t1_alu_rs", 32'(alu_rs), 32'd10);
        check("t1_alu_rt", 32'(alu_rt), 32'd20);
        check("t1_busy_issue", 32'(busy), 32'h1);
        tick();
        check("t1_core_state_capture", 32'(alu_core_state), 32'h0);
        check("t1_enable_capture", 32'(alu_enable), 32'h0);
        check("t1_alu_rs_hold", 32'(alu_rs), 32'd10);
        check("t1_grant_capture", 32'(req_grant), 32'h0);
        check("t1_valid_early", 32'(resp_valid), 32'h0);
        tick();
        check("t1_resp_valid", 32'(resp_valid), 32'h1);
        check("t1_resp_data", 32'(lane_data(0)), 32'd30);
        check("t1_resp_err", 32'(resp_err), 32'h0);
        check("t1_busy_idle", 32'(busy), 32'h0);
        ack(4'b0001);
        check("t1_ack_clears", 32'(resp_valid), 32'h0);

        // All lanes at once from rr_ptr=0: grants 0,1,2,3 every 2 cycles
        do_reset();
        tick();
        set_req(0, 2'b01, 1'b0, 8'd50, 8'd15);
        set_req(1, 2'b10, 1'b0, 8'd7,  8'd6);
        set_req(2, 2'b11, 1'b0, 8'd30, 8'd5);
        set_req(3, 2'b00, 1'b0, 8'd1,  8'd1);
        for (int s = 0; s < 8; s++) begin
            tick();
            check($sformatf("t2_busy_%0d", s), 32'(busy), 32'h1);
            check($sformatf("t2_grant_%0d", s), 32'(req_grant),
                  (s % 2 == 0) ? (32'h1 << (s / 2)) : 32'h0);
            if (s == 2) check("t2_mul_mux", 32'(alu_arith_mux), 32'h2);
        end
        tick();
        check("t2_resp_valid", 32'(resp_valid), 32'hF);
        check("t2_data0", 32'(lane_data(0)), 32'd35);
        check("t2_data1", 32'(lane_data(1)), 32'd42);
        check("t2_data2", 32'(lane_data(2)), 32'd6);
        check("t2_data3", 32'(lane_data(3)), 32'd2);
        check("t2_busy_end", 32'(busy), 32'h0);
        ack(4'b1111);

        // Compare results pass through as {N,Z,P}
        set_req(2, 2'b00, 1'b1, 8'd15, 8'd10);
        set_req(1, 2'b00, 1'b1, 8'd5,  8'd5);
        set_req(3, 2'b00, 1'b1, 8'd3,  8'd7);
        wait_resp(4'b1110, "t3_wait");
        check("t3_cmp_gt", 32'(lane_data(2)), 32'h1);
        check("t3_cmp_eq", 32'(lane_data(1)), 32'h2);
        check("t3_cmp_lt", 32'(lane_data(3)), 32'h4);
        ack(4'b1111);
        check("t3_ack_clears", 32'(resp_valid), 32'h0);

        // Divide by zero; lane1 then blocked until acked while lane0 proceeds
        set_req(1, 2'b11, 1'b0, 8'd9, 8'd0);
        wait_resp(4'b0010, "t4_wait_div");
        check("t4_div_data", 32'(lane_data(1)), 32'hFF);
        check("t4_div_err", 32'(resp_err), 32'h2);
        set_req(1, 2'b00, 1'b0, 8'd2, 8'd3);
        set_req(0, 2'b00, 1'b0, 8'd4, 8'd4);
        gseen = '0;
        repeat (6) tick();
        check("t4_lane1_blocked", 32'(gseen[1]), 32'h0);
        check("t4_lane0_served", 32'(resp_valid), 32'h3);
        check("t4_lane0_data", 32'(lane_data(0)), 32'd8);
        check("t4_lane1_held", 32'(lane_data(1)), 32'hFF);
        ack(4'b0011);
        check("t4_ack_both", 32'(resp_valid), 32'h0);
        wait_resp(4'b0010, "t4_wait_retry");
        check("t4_retry_data", 32'(lane_data(1)), 32'd5);
        check("t4_retry_err", 32'(resp_err), 32'h0);
        ack(4'b0010);

        // rr_ptr now 2: lane3 beats lane0
        set_req(0, 2'b00, 1'b0, 8'd1, 8'd2);
        set_req(3, 2'b01, 1'b0, 8'd9, 8'd4);
        tick();
        check("t5_first_grant", 32'(req_grant), 32'h8);
        tick();
        tick();
        check("t5_second_grant", 32'(req_grant), 32'h1);
        wait_resp(4'b1001, "t5_wait");
        check("t5_data0", 32'(lane_data(0)), 32'd3);
        check("t5_data3", 32'(lane_data(3)), 32'd5);
        ack(4'b1111);
        check("t5_ack_clears", 32'(resp_valid), 32'h0);

        // Asynchronous reset in ISSUE discards the op
        set_req(0, 2'b00, 1'b0, 8'd3, 8'd3);
        tick();
        check("t6_issue_grant", 32'(req_grant), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_grant", 32'(req_grant), 32'h0);
        check("t6_rst_enable", 32'(alu_enable), 32'h0);
        check("t6_rst_core_state", 32'(alu_core_state), 32'h0);
        check("t6_rst_alu_rs", 32'(alu_rs), 32'h0);
        check("t6_rst_alu_rt", 32'(alu_rt), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_resp_data", resp_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        gseen = '0;
        repeat (5) tick();
        check("t6_no_stale_resp", 32'(resp_valid), 32'h0);
        check("t6_no_grant", 32'(gseen), 32'h0);
        set_req(0, 2'b00, 1'b0, 8'd3, 8'd3);
        wait_resp(4'b0001, "t6_wait_rereq");
        check("t6_rereq_data", 32'(lane_data(0)), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
